ccff_chain_loader: RTL and testbench

- Sequencer that streams a configuration bitstream into a tile's configuration-flip-flop (CCFF) shift chain.
- Words arrive over a valid/ready interface and are serialized LSB-first onto ccff_head. The loader emits a shift enable that an external clock gate uses to clock the chain.
- One instance sits at the head of each chain segment, for example the 5-cell IO tile chain. It counts exactly CHAIN_LEN shifts and then reports done.

---
 rtl/ccff_pkg.sv | 20 ++
 rtl/ccff_word_serializer.sv | 75 +++++++
 rtl/ccff_chain_loader.sv | 154 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared types and helpers for the CCFF chain loader.
// The chain-check states are only reachable when CCFF_CHAIN_CHECK_EN is defined.
package ccff_pkg;

    // Sequencer states. CHK_* are used only by the optional pre-load chain check.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_FLUSH = 3'd1,
        CHK_MARK  = 3'd2,
        CHK_WAIT  = 3'd3,
        LOAD      = 3'd4,
        DONE      = 3'd5
    } ccff_state_e;

    // Bits needed to hold any value from 0 up to max_count inclusive.
    function automatic int ccff_cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word serializer for the CCFF chain loader.
// Accepts one configuration word when empty, emits bit 0 in the accept cycle
// and the stored upper bits on the following cycles, LSB first.
module ccff_word_serializer
    import ccff_pkg::*;
#(
    parameter int WORD_W = 8
)
(
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              load_active,
    input  logic              last_shift,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ser_shift,
    output logic              ser_head
);

    localparam int                WB_W      = ccff_cnt_width(WORD_W - 1);
    localparam logic [WB_W-1:0]   WBITS_NEW = WB_W'(WORD_W - 1);
    localparam logic [WB_W-1:0]   WBITS_ONE = WB_W'(1);

    logic [WORD_W-2:0] word_q;
    logic [WB_W-1:0]   wbits_q;
    logic              holding;
    logic              accept;

    assign holding = (wbits_q != '0);
    assign accept  = load_active && !holding && cfg_valid;

    // Ready, shift enable and head bit for the current cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        cfg_ready = 1'b0;
        ser_shift = 1'b0;
        ser_head  = 1'b0;
        if (load_active) begin
            cfg_ready = !holding;
            if (holding) begin
                ser_shift = 1'b1;
                ser_head  = word_q[0];
            end else if (cfg_valid) begin
                ser_shift = 1'b1;
                ser_head  = cfg_data[0];
            end
        end
    end

    // Remaining-bit counter; the final chain shift drops any leftover bits.
    always_ff @(posedge prog_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!prog_reset_n) begin
            wbits_q <= '0;
        end else if (last_shift) begin
            wbits_q <= '0;
        end else if (accept) begin
            wbits_q <= WBITS_NEW;
        end else if (load_active && holding) begin
            wbits_q <= wbits_q - WBITS_ONE;
        end
    end

    // Stored upper word bits, shifted down as each one goes out.
    always_ff @(posedge prog_clk) begin
        // NOTE: word_q is pure datapath qualified by wbits_q, so it carries no reset.
        if (accept) begin
            word_q <= cfg_data[WORD_W-1:1];
        end else if (load_active && holding) begin
            word_q <= word_q >> 1;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// CCFF chain loader: streams configuration words LSB first into a CCFF shift
// chain, counting exactly CHAIN_LEN shifts before reporting done.
// Optional pre-load chain check is enabled by defining CCFF_CHAIN_CHECK_EN.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 5,
    parameter int WORD_W    = 8
)
(
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int               CNT_W    = ccff_cnt_width(CHAIN_LEN);
    localparam logic [CNT_W-1:0] REM_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] REM_PRE  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);

    ccff_state_e      state;
    logic [CNT_W-1:0] rem;
    logic             busy_q;
    logic             done_q;
    logic             load_active;
    logic             last_shift;
    logic             ser_shift;
    logic             ser_head;
    logic             chk_shift;
    logic             chk_head;

    assign load_active = (state == LOAD);
    assign last_shift  = load_active && ser_shift && (rem == REM_ONE);

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .load_active  (load_active),
        .last_shift   (last_shift),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ser_shift    (ser_shift),
        .ser_head     (ser_head)
    );

`ifdef CCFF_CHAIN_CHECK_EN
    logic error_q;
    logic first_wait;

    // Check phases shift every cycle; only CHK_MARK drives a 1 into the chain.
    assign chk_shift  = (state == CHK_FLUSH) || (state == CHK_MARK) || (state == CHK_WAIT);
    assign chk_head   = (state == CHK_MARK);
    assign first_wait = (state == CHK_WAIT) && (rem == REM_PRE);
    assign error      = error_q;
`else
    logic unused_tail;

    assign chk_shift   = 1'b0;
    assign chk_head    = 1'b0;
    assign unused_tail = ccff_tail;
    assign error       = 1'b0;
`endif

    // Serializer data and check pattern are never active together, so OR merges them.
    assign ccff_shift_en = ser_shift | chk_shift;
    assign ccff_head     = ser_head | chk_head;
    assign busy          = busy_q;
    assign done          = done_q;

    // Sequencer: state, shift budget and registered status flags.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state  <= IDLE;
            rem    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef CCFF_CHAIN_CHECK_EN
            error_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
`ifdef CCFF_CHAIN_CHECK_EN
                        error_q <= 1'b0;
                        state   <= CHK_FLUSH;
                        rem     <= REM_PRE;
`else
                        state   <= LOAD;
                        rem     <= REM_FULL;
`endif
                    end
                end
`ifdef CCFF_CHAIN_CHECK_EN
                CHK_FLUSH: begin
                    rem <= rem - REM_ONE;
                    if (rem == REM_ONE) begin
                        state <= CHK_MARK;
                    end
                end
                CHK_MARK: begin
                    rem   <= REM_PRE;
                    state <= CHK_WAIT;
                end
                CHK_WAIT: begin
                    if (first_wait && !ccff_tail) begin
                        // Marker did not reach the tail: report a broken chain, skip the load.
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        rem     <= '0;
                        state   <= DONE;
                    end else if (rem == REM_ONE) begin
                        rem   <= REM_FULL;
                        state <= LOAD;
                    end else begin
                        rem <= rem - REM_ONE;
                    end
                end
`endif
                LOAD: begin
                    if (ser_shift) begin
                        rem <= rem - REM_ONE;
                        if (rem == REM_ONE) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader: a 5-cell and a 20-cell instance, driven
// with directed and $urandom stimulus. Expected head streams, acceptance and
// stall counts come from a word-list model; the check-build tests only
// compile when CCFF_CHAIN_CHECK_EN is defined.
module tb_ccff_chain_loader;

    localparam int WORD_W = 8;
    localparam int BUDGET = 400;

    logic prog_clk = 1'b0;
    logic prog_reset_n;

    logic [1:0]        start_s;
    logic [1:0]        valid_s;
    logic [1:0]        tail_s;
    logic [1:0]        ready_s;
    logic [1:0]        head_s;
    logic [1:0]        sen_s;
    logic [1:0]        busy_s;
    logic [1:0]        done_s;
    logic [1:0]        err_s;
    logic [WORD_W-1:0] data_s [2];
    logic [1:0]        stuck;
    logic [19:0]       chain_q [2];

    int total = 0;
    int bad   = 0;

    // Words offered in the next sequence and idle ready-cycles before each word.
    logic [WORD_W-1:0] wq [$];
    int                gq [$];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(5), .WORD_W(WORD_W)) dut_short (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start_s[0]),
        .cfg_data      (data_s[0]),
        .cfg_valid     (valid_s[0]),
        .cfg_ready     (ready_s[0]),
        .ccff_head     (head_s[0]),
        .ccff_shift_en (sen_s[0]),
        .ccff_tail     (tail_s[0]),
        .busy          (busy_s[0]),
        .done          (done_s[0]),
        .error         (err_s[0])
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(WORD_W)) dut_long (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start_s[1]),
        .cfg_data      (data_s[1]),
        .cfg_valid     (valid_s[1]),
        .cfg_ready     (ready_s[1]),
        .ccff_head     (head_s[1]),
        .ccff_shift_en (sen_s[1]),
        .ccff_tail     (tail_s[1]),
        .busy          (busy_s[1]),
        .done          (done_s[1]),
        .error         (err_s[1])
    );

    // Chain stand-in: captures head on enabled cycles; the observed tap is the
    // most recently captured cell, or forced low to model a stuck cell.
    always @(posedge prog_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!prog_reset_n)
                chain_q[i] <= '0;
            else if (sen_s[i] === 1'b1)
                chain_q[i] <= {chain_q[i][18:0], head_s[i]};
        end
    end
    assign tail_s[0] = ~stuck[0] & chain_q[0][0];
    assign tail_s[1] = ~stuck[1] & chain_q[1][0];

    function automatic int len_of(input int u);
        return (u == 0) ? 5 : 20;
    endfunction

    // One load sequence on unit u: start, feed wq/gq, record every shifted bit,
    // then compare against the model. abort_at >= 0 resets after that many shifts.
    task automatic run_seq(input int u, input int glitch_at, input int abort_at,
                           input bit exp_err, input string tag);
        int len;
        int data_bits;
        int gap_left;
        int wi;
        int accepts;
        int idle;
        int exp_accepts;
        int exp_idle;
        int bit_bad;
        int first_bad;
        bit exp_bits [$];
        bit got [$];
        bit seen_done;
        bit ready_seen;
        bit first;
        bit aborted;

        len       = len_of(u);
        data_bits = 0;
        accepts   = 0;
        idle      = 0;
        bit_bad   = 0;
        first_bad = -1;
        seen_done = 1'b0;
        ready_seen = 1'b0;
        first     = 1'b1;
        aborted   = 1'b0;

        // Model: check pattern (when built in), then words LSB first, cut at len.
`ifdef CCFF_CHAIN_CHECK_EN
        for (int i = 0; i < len - 1; i++) exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1);
        if (exp_err) exp_bits.push_back(1'b0);
        else for (int i = 0; i < len - 1; i++) exp_bits.push_back(1'b0);
`endif
        if (!exp_err) begin
            for (int w = 0; w < wq.size(); w++)
                for (int b = 0; b < WORD_W; b++)
                    if (data_bits < len) begin
                        exp_bits.push_back(wq[w][b]);
                        data_bits++;
                    end
        end
        exp_accepts = exp_err ? 0 : (len + WORD_W - 1) / WORD_W;
        exp_idle = 0;
        for (int w = 0; w < exp_accepts && w < gq.size(); w++) exp_idle += gq[w];

        @(posedge prog_clk); #1;
        start_s[u] = 1'b1;
        valid_s[u] = 1'b0;
        @(posedge prog_clk); #1;
        wi = 0;
        gap_left = (gq.size() > 0) ? gq[0] : 0;

        for (int cyc = 0; cyc < BUDGET && !seen_done && !aborted; cyc++) begin
            start_s[u] = (cyc == glitch_at);
            if (wi < wq.size() && gap_left > 0) begin
                valid_s[u] = 1'b0;
                if (ready_s[u] === 1'b1) gap_left--;
            end else begin
                valid_s[u] = 1'b1;
                data_s[u]  = (wi < wq.size()) ? wq[wi] : WORD_W'($urandom);
            end
            @(negedge prog_clk);
            if (first) begin
                total++;
                if (done_s[u] !== 1'b0 || busy_s[u] !== 1'b1 || err_s[u] !== 1'b0) begin
                    bad++;
                    $display("FAIL %s restart: done=%b busy=%b error=%b, need 0 1 0",
                             tag, done_s[u], busy_s[u], err_s[u]);
                end
                first = 1'b0;
            end
            if (ready_s[u] === 1'b1) ready_seen = 1'b1;
            if (sen_s[u] === 1'b1) begin
                got.push_back(head_s[u]);
            end else begin
                total++;
                if (head_s[u] !== 1'b0) begin
                    bad++;
                    $display("FAIL %s head_idle: head=%b with shift_en low, need 0", tag, head_s[u]);
                end
            end
            if (busy_s[u] === 1'b1 && sen_s[u] !== 1'b1) idle++;
            if (valid_s[u] && ready_s[u] === 1'b1) begin
                accepts++;
                wi++;
                gap_left = (wi < gq.size()) ? gq[wi] : 0;
            end
            if (done_s[u] === 1'b1) seen_done = 1'b1;
            if (abort_at >= 0 && got.size() == abort_at && !seen_done) begin
                @(posedge prog_clk); #1;
                prog_reset_n = 1'b0;
                @(posedge prog_clk);
                @(negedge prog_clk);
                total++;
                if ({ready_s[u], head_s[u], sen_s[u], busy_s[u], done_s[u], err_s[u]} !== 6'b0) begin
                    bad++;
                    $display("FAIL %s reset_mid: ready/head/shift/busy/done/error=%b, need 000000", tag,
                             {ready_s[u], head_s[u], sen_s[u], busy_s[u], done_s[u], err_s[u]});
                end
                prog_reset_n = 1'b1;
                aborted = 1'b1;
            end else if (!seen_done) begin
                @(posedge prog_clk); #1;
            end
        end

        if (!aborted) begin
            total++;
            if (!seen_done) begin
                bad++;
                $display("FAIL %s timeout: done not seen within %0d cycles", tag, BUDGET);
            end else begin
                total++;
                if (busy_s[u] !== 1'b0 || sen_s[u] !== 1'b0 || ready_s[u] !== 1'b0 || err_s[u] !== exp_err) begin
                    bad++;
                    $display("FAIL %s done_outputs: busy=%b shift=%b ready=%b error=%b, need 0 0 0 %b",
                             tag, busy_s[u], sen_s[u], ready_s[u], err_s[u], exp_err);
                end
                for (int i = 0; i < got.size() && i < exp_bits.size(); i++)
                    if (got[i] !== exp_bits[i]) begin
                        bit_bad++;
                        if (first_bad < 0) first_bad = i;
                    end
                total++;
                if (got.size() != exp_bits.size() || bit_bad != 0) begin
                    bad++;
                    $display("FAIL %s stream: %0d shifts with %0d wrong bits (first at %0d), need %0d shifts",
                             tag, got.size(), bit_bad, first_bad, exp_bits.size());
                end
                total++;
                if (accepts != exp_accepts) begin
                    bad++;
                    $display("FAIL %s accepts: got %0d words, need %0d", tag, accepts, exp_accepts);
                end
                total++;
                if (idle != exp_idle) begin
                    bad++;
                    $display("FAIL %s stall_cycles: got %0d, need %0d", tag, idle, exp_idle);
                end
                total++;
                if (ready_seen != !exp_err) begin
                    bad++;
                    $display("FAIL %s ready_seen: got %b, need %b", tag, ready_seen, !exp_err);
                end
                // Offer one more word after completion: it must be refused and done held.
                @(posedge prog_clk); #1;
                start_s[u] = 1'b0;
                valid_s[u] = 1'b1;
                data_s[u]  = WORD_W'($urandom);
                @(negedge prog_clk);
                total++;
                if (ready_s[u] !== 1'b0 || done_s[u] !== 1'b1 || sen_s[u] !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done_hold: ready=%b done=%b shift=%b, need 0 1 0",
                             tag, ready_s[u], done_s[u], sen_s[u]);
                end
            end
        end
        start_s[u] = 1'b0;
        valid_s[u] = 1'b0;
    endtask

    task automatic test_reset();
        prog_reset_n = 1'b0;
        start_s = 2'b11;
        valid_s = 2'b11;
        data_s[0] = 8'hFF;
        data_s[1] = 8'hFF;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if ({ready_s[u], head_s[u], sen_s[u], busy_s[u], done_s[u], err_s[u]} !== 6'b0) begin
                bad++;
                $display("FAIL reset_state unit %0d: ready/head/shift/busy/done/error=%b, need 000000", u,
                         {ready_s[u], head_s[u], sen_s[u], busy_s[u], done_s[u], err_s[u]});
            end
        end
        start_s = 2'b00;
        valid_s = 2'b00;
        prog_reset_n = 1'b1;
        @(posedge prog_clk); #1;
    endtask

    task automatic test_single_word();
        wq = '{8'h15};
        gq = '{0};
        run_seq(0, -1, -1, 1'b0, "single_word");
    endtask

    task automatic test_gap_multi();
        wq = '{8'hA5, 8'h3C, 8'h0F};
        gq = '{0, 3, 0};
        run_seq(1, -1, -1, 1'b0, "gap_multi");
    endtask

    task automatic test_reset_mid();
        wq = '{WORD_W'($urandom)};
        gq = '{0};
        run_seq(0, -1, 3, 1'b0, "reset_mid");
        wq = '{WORD_W'($urandom)};
        run_seq(0, -1, -1, 1'b0, "after_reset");
    endtask

    task automatic test_start_ignored();
        wq = '{8'h6B};
        gq = '{0};
        run_seq(0, 2, -1, 1'b0, "start_ignored_short");
        wq = '{8'hC3, 8'h5A, 8'h96};
        gq = '{0, 1, 2};
        run_seq(1, 9, -1, 1'b0, "start_ignored_long");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            wq = '{WORD_W'($urandom), WORD_W'($urandom), WORD_W'($urandom)};
            gq = '{0, 0, 0};
            run_seq(1, -1, -1, 1'b0, "back_to_back");
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int u;
            int nw;
            u  = k % 2;
            nw = (len_of(u) + WORD_W - 1) / WORD_W;
            wq.delete();
            gq.delete();
            for (int w = 0; w < nw; w++) begin
                wq.push_back(WORD_W'($urandom));
                gq.push_back($urandom_range(0, 3));
            end
            run_seq(u, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 25) : -1, -1, 1'b0, "random");
        end
    endtask

`ifdef CCFF_CHAIN_CHECK_EN
    task automatic test_chain_check();
        wq = '{8'h9D};
        gq = '{0};
        stuck = 2'b00;
        run_seq(0, -1, -1, 1'b0, "check_good");
        stuck = 2'b01;
        run_seq(0, -1, -1, 1'b1, "check_stuck");
        stuck = 2'b00;
        run_seq(0, -1, -1, 1'b0, "check_recover");
    endtask
`endif

    initial begin
        stuck        = 2'b00;
        start_s      = 2'b00;
        valid_s      = 2'b00;
        data_s[0]    = '0;
        data_s[1]    = '0;
        prog_reset_n = 1'b0;
        test_reset();
        test_single_word();
        test_gap_multi();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        test_random();
`ifdef CCFF_CHAIN_CHECK_EN
        test_chain_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
